frame_stack: RTL and testbench
==============================

FRAME_STACK -- requirements
Module: frame_stack

Interface
REQ-001 Parameter DEPTH, default 16, number of call-frame entries (power of two, 2..64).
REQ-002 Parameter AW, default 11, width of saved PC and saved SP fields.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 call_2a  input  1  call instruction in decode; capture stack pointer.
REQ-006 call_3a  input  1  same call now in execute; commit frame.
REQ-007 ret_2a  input  1  return instruction in decode; pop frame.
REQ-008 kill_4a  input  1  pipeline flush; cancels a captured, uncommitted call.
REQ-009 st__sp_2a  input  AW  data-stack pointer sampled with call_2a.
REQ-010 st__saved_pc_3a  input  AW  return PC sampled with call_3a.
REQ-011 st__saved_pc_2a  output  AW  return PC of top frame, combinational view.
REQ-012 st__saved_sp_3a  output  AW  saved SP of frame popped in previous cycle, registered.
REQ-013 frm_depth  output  log2(DEPTH)+1  number of valid frames.
REQ-014 frm_overflow  output  1  sticky: commit attempted while full.
REQ-015 frm_underflow  output  1  sticky: pop attempted while empty.

Function
REQ-016 Cycle with call_2a: st__sp_2a latched into pending-SP register, pending-valid set.
REQ-017 Cycle with call_3a and pending-valid: entry {pending SP, st__saved_pc_3a} written at index frm_depth, depth +1, pending-valid cleared unless call_2a also asserted that cycle.
REQ-018 call_3a with pending-valid clear: no write, no flag.
REQ-019 kill_4a: pending-valid cleared same edge; no effect on committed entries; kill_4a wins over call_2a in that cycle.
REQ-020 st__saved_pc_2a: PC field of entry depth-1 when depth>0, else 0; no added latency.
REQ-021 ret_2a with depth>0: depth -1; st__saved_sp_3a loads that entry's SP field at the same edge (1-cycle latency).
REQ-022 ret_2a with depth=0: depth unchanged, st__saved_sp_3a loads 0, frm_underflow set.
REQ-023 Commit with depth=DEPTH and no simultaneous pop: write dropped, frm_overflow set, pending-valid cleared.
REQ-024 Simultaneous pop (ret_2a) and commit (call_3a): pop reads current top first; commit writes to index depth-1 (slot vacated); depth unchanged; legal when full; when empty behaves as REQ-022 plus a normal commit to index 0.
REQ-025 st__saved_sp_3a holds its value between pops.
REQ-026 Sticky flags clear only on reset.
REQ-027 Depth counter never wraps; saturates at 0 and DEPTH.

Reset
REQ-028 rst_b low: depth 0, pending-valid 0, pending SP 0, st__saved_sp_3a 0, both flags 0, immediately and asynchronously.
REQ-029 Entry storage contents need not be reset; with depth 0, st__saved_pc_2a reads 0.
REQ-030 Reset mid-call (between call_2a and call_3a): captured SP discarded; later call_3a writes nothing.

Structure
REQ-031 Shared cpu package holds AW, DEPTH default and the frame-entry struct {sp, pc}.
REQ-032 One sub-module frame_stack_ram: DEPTH x 2*AW register file, one write port, one asynchronous read port, no reset.
REQ-033 Control, pointer, pending register and flags reside in frame_stack.

Verification
REQ-034 call_2a sp=0x12A, next cycle call_3a pc=0x040 -> depth=1, st__saved_pc_2a=0x040; ret_2a -> next cycle st__saved_sp_3a=0x12A, depth=0.
REQ-035 call_2a sp=0x005, next cycle kill_4a with call_3a -> depth stays 0, no flags.
REQ-036 17 committed calls with DEPTH=16 -> depth=16, frm_overflow=1, top PC equals 16th call's PC.
REQ-037 ret_2a at depth 0 -> frm_underflow=1, st__saved_sp_3a=0, depth 0.
REQ-038 Depth 16, ret_2a with call_3a same cycle (pc=0x7FF, sp=0x001) -> depth 16, st__saved_sp_3a=old top SP, new top PC=0x7FF, no overflow.
REQ-039 rst_b low asynchronously at depth 3 with pending call -> all outputs 0 before next clk edge.

Source files
------------

// File: rtl/frame_stack_pkg.sv
// Shared definitions for the call-frame stack: default sizing and the frame entry layout.
package frame_stack_pkg;

    localparam int unsigned FS_AW    = 11;
    localparam int unsigned FS_DEPTH = 16;

    // One call frame: saved data-stack pointer and saved return PC.
    typedef struct packed {
        logic [FS_AW-1:0] sp;
        logic [FS_AW-1:0] pc;
    } frame_entry_t;

endpackage : frame_stack_pkg

// File: rtl/frame_stack_if.sv
// Pipeline-facing signals of the call-frame stack.
//   master : pipeline side (drives call/ret/kill requests, samples stack outputs)
//   slave  : frame_stack side
interface frame_stack_if
    import frame_stack_pkg::*;
#(
    parameter int unsigned AW    = FS_AW,
    parameter int unsigned DEPTH = FS_DEPTH
);
    localparam int unsigned DW = $clog2(DEPTH) + 1;

    logic          call_2a;
    logic          call_3a;
    logic          ret_2a;
    logic          kill_4a;
    logic [AW-1:0] st__sp_2a;
    logic [AW-1:0] st__saved_pc_3a;
    logic [AW-1:0] st__saved_pc_2a;
    logic [AW-1:0] st__saved_sp_3a;
    logic [DW-1:0] frm_depth;
    logic          frm_overflow;
    logic          frm_underflow;

    modport master (
        output call_2a, call_3a, ret_2a, kill_4a, st__sp_2a, st__saved_pc_3a,
        input  st__saved_pc_2a, st__saved_sp_3a, frm_depth, frm_overflow, frm_underflow
    );

    modport slave (
        input  call_2a, call_3a, ret_2a, kill_4a, st__sp_2a, st__saved_pc_3a,
        output st__saved_pc_2a, st__saved_sp_3a, frm_depth, frm_overflow, frm_underflow
    );

endinterface : frame_stack_if

// File: rtl/frame_stack_ram.sv
// Frame storage: DEPTH x W register file, one synchronous write port, one
// asynchronous read port, contents not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational)
module frame_stack_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 22
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : frame_stack_ram

// File: rtl/frame_stack.sv
// Hardware call-frame stack. A call captures the data-stack pointer in decode
// and commits {sp, return pc} in execute; a flush cancels a captured call; a
// return pops the top frame and presents its saved SP one cycle later.
//   clk   : clock
//   rst_b : asynchronous active-low reset
//   bus   : pipeline interface (slave modport)
//     call_2a/st__sp_2a          capture pending SP
//     call_3a/st__saved_pc_3a    commit pending frame
//     ret_2a                     pop top frame
//     kill_4a                    cancel pending frame
//     st__saved_pc_2a            top-frame PC (combinational, 0 when empty)
//     st__saved_sp_3a            SP of last popped frame (registered)
//     frm_depth                  valid frame count
//     frm_overflow/frm_underflow sticky error flags
module frame_stack
    import frame_stack_pkg::*;
#(
    parameter int unsigned DEPTH = FS_DEPTH,
    parameter int unsigned AW    = FS_AW
) (
    input  logic               clk,
    input  logic               rst_b,
    frame_stack_if.slave       bus
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned DW = IW + 1;

    // Same layout as frame_entry_t, sized by this instance's AW.
    typedef struct packed {
        logic [AW-1:0] sp;
        logic [AW-1:0] pc;
    } entry_t;

    logic [DW-1:0] depth_q,    depth_d;
    logic          pend_vld_q, pend_vld_d;
    logic [AW-1:0] pend_sp_q,  pend_sp_d;
    logic [AW-1:0] saved_sp_q, saved_sp_d;
    logic          ovf_q,      ovf_d;
    logic          unf_q,      unf_d;

    logic          empty;
    logic          full;
    logic          commit;
    logic          pop;
    logic [IW-1:0] top_idx;
    logic          we;
    logic [IW-1:0] wr_idx;
    entry_t        wr_entry;
    entry_t        rd_entry;

    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DW'(DEPTH));
    assign top_idx = IW'(depth_q - DW'(1));
    assign pop     = bus.ret_2a;
    // A flush in the commit cycle cancels the frame before it lands.
    assign commit  = bus.call_3a && pend_vld_q && !bus.kill_4a;

    assign wr_entry = '{sp: pend_sp_q, pc: bus.st__saved_pc_3a};

    frame_stack_ram #(
        .DEPTH (DEPTH),
        .W     (2 * AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_idx),
        .wdata (wr_entry),
        .raddr (top_idx),
        .rdata (rd_entry)
    );

    // Next-state: pop reads the current top before any same-cycle commit lands.
    always_comb begin
        depth_d    = depth_q;
        pend_vld_d = pend_vld_q;
        pend_sp_d  = pend_sp_q;
        saved_sp_d = saved_sp_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        we         = 1'b0;
        wr_idx     = IW'(depth_q);

        if (pop) begin
            if (empty) begin
                saved_sp_d = '0;
                unf_d      = 1'b1;
            end else begin
                saved_sp_d = rd_entry.sp;
                depth_d    = depth_q - DW'(1);
            end
        end

        if (commit) begin
            if (pop && !empty) begin
                // Reuse the slot just vacated; depth nets to unchanged.
                we      = 1'b1;
                wr_idx  = top_idx;
                depth_d = depth_q;
            end else if (full && !pop) begin
                ovf_d = 1'b1;
            end else begin
                we      = 1'b1;
                wr_idx  = IW'(depth_q);
                depth_d = depth_q + DW'(1);
            end
        end

        // Kill beats a new capture; any execute-stage call consumes the pending frame.
        if (bus.kill_4a) begin
            pend_vld_d = 1'b0;
        end else if (bus.call_2a) begin
            pend_vld_d = 1'b1;
            pend_sp_d  = bus.st__sp_2a;
        end else if (bus.call_3a) begin
            pend_vld_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            depth_q    <= '0;
            pend_vld_q <= 1'b0;
            pend_sp_q  <= '0;
            saved_sp_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            depth_q    <= depth_d;
            pend_vld_q <= pend_vld_d;
            pend_sp_q  <= pend_sp_d;
            saved_sp_q <= saved_sp_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign bus.st__saved_pc_2a = empty ? '0 : rd_entry.pc;
    assign bus.st__saved_sp_3a = saved_sp_q;
    assign bus.frm_depth       = depth_q;
    assign bus.frm_overflow    = ovf_q;
    assign bus.frm_underflow   = unf_q;

endmodule : frame_stack

// File: tb/tb_frame_stack.sv
// Directed bench for frame_stack: a vector table for single-cycle behaviour
// plus hand-written sequences for fill/overflow, full pop+commit and resets.
module tb_frame_stack;
    import frame_stack_pkg::*;

    logic clk = 1'b0;
    logic rst_b;

    always #5 clk = ~clk;

    frame_stack_if #(.AW(FS_AW), .DEPTH(FS_DEPTH)) bus ();

    frame_stack #(.DEPTH(FS_DEPTH), .AW(FS_AW)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          c2;
        bit          c3;
        bit          r;
        bit          k;
        logic [10:0] sp;
        logic [10:0] pc;
        int unsigned d;
        int unsigned pc2;
        int unsigned sp3;
        int unsigned ov;
        int unsigned un;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    frame_entry_t model [$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int unsigned d, input int unsigned pc2,
                           input int unsigned sp3, input int unsigned ov, input int unsigned un);
        chk({tag, ".depth"},     int'(bus.frm_depth),       d);
        chk({tag, ".pc2a"},      int'(bus.st__saved_pc_2a), pc2);
        chk({tag, ".sp3a"},      int'(bus.st__saved_sp_3a), sp3);
        chk({tag, ".overflow"},  int'(bus.frm_overflow),    ov);
        chk({tag, ".underflow"}, int'(bus.frm_underflow),   un);
    endtask

    task automatic drive(input bit c2, input bit c3, input bit r, input bit k,
                         input logic [10:0] sp, input logic [10:0] pc);
        bus.call_2a         = c2;
        bus.call_3a         = c3;
        bus.ret_2a          = r;
        bus.kill_4a         = k;
        bus.st__sp_2a       = sp;
        bus.st__saved_pc_3a = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 11'h0, 11'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        model.delete();
    endtask

    // Full call: capture in one cycle, commit the next; model mirrors the architectural stack.
    task automatic do_call(input logic [10:0] sp, input logic [10:0] pc);
        drive(1, 0, 0, 0, sp, 11'h0);
        step();
        drive(0, 1, 0, 0, 11'h0, pc);
        step();
        if (model.size() < FS_DEPTH) model.push_back('{sp: sp, pc: pc});
    endtask

    initial begin
        //             c2 c3 r  k  sp      pc      depth pc2     sp3     ov un
        vecs[0]  = '{0, 0, 0, 0, 11'h000, 11'h000, 0, 'h000, 'h000, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 11'h12A, 11'h000, 0, 'h000, 'h000, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 11'h000, 11'h040, 1, 'h040, 'h000, 0, 0};
        vecs[3]  = '{0, 0, 1, 0, 11'h000, 11'h000, 0, 'h000, 'h12A, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 11'h005, 11'h000, 0, 'h000, 'h12A, 0, 0};
        vecs[5]  = '{0, 1, 0, 1, 11'h000, 11'h111, 0, 'h000, 'h12A, 0, 0};
        vecs[6]  = '{0, 1, 0, 0, 11'h000, 11'h222, 0, 'h000, 'h12A, 0, 0};
        vecs[7]  = '{1, 0, 0, 0, 11'h0A1, 11'h000, 0, 'h000, 'h12A, 0, 0};
        vecs[8]  = '{1, 1, 0, 0, 11'h0A2, 11'h0B1, 1, 'h0B1, 'h12A, 0, 0};
        vecs[9]  = '{0, 1, 0, 0, 11'h000, 11'h0B2, 2, 'h0B2, 'h12A, 0, 0};
        vecs[10] = '{0, 0, 1, 0, 11'h000, 11'h000, 1, 'h0B1, 'h0A2, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 11'h000, 11'h000, 1, 'h0B1, 'h0A2, 0, 0};
        vecs[12] = '{0, 0, 1, 0, 11'h000, 11'h000, 0, 'h000, 'h0A1, 0, 0};
        vecs[13] = '{0, 0, 1, 0, 11'h000, 11'h000, 0, 'h000, 'h000, 0, 1};
        vecs[14] = '{1, 0, 0, 1, 11'h333, 11'h000, 0, 'h000, 'h000, 0, 1};
        vecs[15] = '{0, 1, 0, 0, 11'h000, 11'h444, 0, 'h000, 'h000, 0, 1};
        vecs[16] = '{1, 0, 0, 0, 11'h055, 11'h000, 0, 'h000, 'h000, 0, 1};
        vecs[17] = '{0, 1, 1, 0, 11'h000, 11'h066, 1, 'h066, 'h000, 0, 1};

        // Power-on reset, checked while reset is still asserted
        rst_b = 1'b0;
        drive(0, 0, 0, 0, 11'h0, 11'h0);
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].c2, vecs[i].c3, vecs[i].r, vecs[i].k, vecs[i].sp, vecs[i].pc);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].pc2, vecs[i].sp3,
                    vecs[i].ov, vecs[i].un);
        end
        drive(0, 0, 0, 0, 11'h0, 11'h0);

        // Fill to 16 frames, then one more commit overflows
        do_reset();
        for (int i = 0; i < 16; i++) do_call(11'(12'h100 + i), 11'(12'h200 + i));
        chk_all("full16", 16, 'h20F, 0, 0, 0);
        do_call(11'h1FF, 11'h3FF);
        chk_all("call17", 16, 'h20F, 0, 1, 0);

        // Full stack: pop and commit together
        do_reset();
        for (int i = 0; i < 16; i++) do_call(11'(12'h100 + i), 11'(12'h200 + i));
        drive(1, 0, 0, 0, 11'h001, 11'h0);
        step();
        drive(0, 1, 1, 0, 11'h0, 11'h7FF);
        step();
        chk_all("popcommit_full", 16, 'h7FF, int'(model[15].sp), 0, 0);
        model[15] = '{sp: 11'h001, pc: 11'h7FF};

        // Drain everything; each pop returns the model's top SP
        for (int i = 15; i >= 0; i--) begin
            drive(0, 0, 1, 0, 11'h0, 11'h0);
            step();
            chk($sformatf("drain%0d.sp3a", i), int'(bus.st__saved_sp_3a), int'(model[i].sp));
            chk($sformatf("drain%0d.depth", i), int'(bus.frm_depth), i);
        end
        chk("drained.pc2a", int'(bus.st__saved_pc_2a), 0);
        chk("drained.underflow", int'(bus.frm_underflow), 0);

        // Asynchronous reset at depth 3 with a pending call
        do_reset();
        do_call(11'h011, 11'h021);
        do_call(11'h012, 11'h022);
        do_call(11'h013, 11'h023);
        drive(0, 0, 1, 0, 11'h0, 11'h0);
        step();
        drive(0, 0, 1, 0, 11'h0, 11'h0);
        step();
        chk_all("pre_async", 1, 'h021, 'h012, 0, 0);
        drive(0, 0, 1, 0, 11'h0, 11'h0);
        step();
        drive(0, 0, 1, 0, 11'h0, 11'h0);
        step();
        chk_all("pre_async_unf", 0, 0, 'h000, 0, 1);
        do_reset();
        do_call(11'h011, 11'h021);
        do_call(11'h012, 11'h022);
        do_call(11'h013, 11'h023);
        do_call(11'h014, 11'h024);
        drive(0, 0, 1, 0, 11'h0, 11'h0);
        step();
        drive(1, 0, 0, 0, 11'h077, 11'h0);
        step();
        chk_all("depth3_pending", 3, 'h023, 'h014, 0, 0);
        #2;
        rst_b = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        // The captured SP was discarded, so this commit must not land
        drive(0, 1, 0, 0, 11'h0, 11'h123);
        step();
        chk_all("post_reset_commit", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_frame_stack
